// File: rtl/calc_sched.sv
// calc_sched: round-robin scheduler between two requesters sharing a single
// serial arithmetic core.
//
// A granted job is fed to the core as up to three strobed words: operand A,
// the opcode, and operand B (binary opcodes only). Each word is separated by
// one idle cycle. The scheduler then captures the core's registered result
// and reports it with a one-cycle done pulse. Invalid opcodes are acknowledged
// together with err, and the core is never touched for them.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   req0/req1          requests, held high until the matching ack
//   a0/a1, b0/b1       8-bit operands (B ignored for unary opcodes)
//   op0/op1            3-bit opcodes
//   ack0/ack1          one-cycle pulse: request accepted, operands latched
//   err                one-cycle pulse with ack: opcode rejected
//   done, rid, res     result pulse, requester id, result (held until next done)
//   busy               high whenever the scheduler is not idle
//   c_rst              core reset (follows rst directly)
//   c_valid, c_data    registered core entry strobe and data
//   c_result           core registered result
module calc_sched #(
  parameter int FIRST_PRIO = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] a0,
  input  logic [7:0] a1,
  input  logic [2:0] op0,
  input  logic [2:0] op1,
  input  logic [7:0] b0,
  input  logic [7:0] b1,
  output logic       ack0,
  output logic       ack1,
  output logic       done,
  output logic       rid,
  output logic [7:0] res,
  output logic       err,
  output logic       busy,
  output logic       c_rst,
  output logic       c_valid,
  output logic [7:0] c_data,
  input  logic [7:0] c_result
);

  typedef enum logic [3:0] {
    IDLE,
    SEND_A,
    GAP_A,
    SEND_OP,
    GAP_OP,
    SEND_B,
    WAIT,
    DONE,
    REJECT
  } state_t;

  state_t     state;
  logic [7:0] job_a;
  logic [7:0] job_b;
  logic [2:0] job_op;
  logic       job_id;
  logic       last_id;

  logic       any_req;
  logic       win_id;
  logic [7:0] win_a;
  logic [7:0] win_b;
  logic [2:0] win_op;
  logic       win_op_ok;
  logic       job_unary;

  // The core shares our reset so both sides restart in step.
  assign c_rst = rst;
  assign busy  = (state != IDLE);

  // On a tie the requester that was not served last wins; a lone request
  // always wins regardless of the pointer.
  always_comb begin
    any_req = req0 | req1;
    if (req0 && req1) begin
      win_id = ~last_id;
    end else begin
      win_id = req1;
    end
  end

  assign win_a     = win_id ? a1 : a0;
  assign win_b     = win_id ? b1 : b0;
  assign win_op    = win_id ? op1 : op0;
  assign win_op_ok = (win_op[2:1] != 2'b11);
  assign job_unary = (job_op == 3'd3) || (job_op == 3'd4) || (job_op == 3'd5);

  // All outputs are registered. Each is assigned on the edge that enters the
  // state it belongs to, so the pulse lines up with that state's cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      c_valid <= 1'b0;
      c_data  <= 8'd0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      rid     <= 1'b0;
      res     <= 8'd0;
      job_a   <= 8'd0;
      job_b   <= 8'd0;
      job_op  <= 3'd0;
      job_id  <= 1'b0;
      last_id <= (FIRST_PRIO == 0);
    end else begin
      c_valid <= 1'b0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            job_a   <= win_a;
            job_b   <= win_b;
            job_op  <= win_op;
            job_id  <= win_id;
            // The pointer advances on rejected grants too.
            last_id <= win_id;
            ack0    <= ~win_id;
            ack1    <= win_id;
            if (win_op_ok) begin
              state   <= SEND_A;
              c_valid <= 1'b1;
              c_data  <= win_a;
            end else begin
              state <= REJECT;
              err   <= 1'b1;
            end
          end
        end
        SEND_A: begin
          state <= GAP_A;
        end
        GAP_A: begin
          state   <= SEND_OP;
          c_valid <= 1'b1;
          c_data  <= {5'b0, job_op};
        end
        SEND_OP: begin
          if (job_unary) begin
            state <= WAIT;
          end else begin
            state <= GAP_OP;
          end
        end
        GAP_OP: begin
          state   <= SEND_B;
          c_valid <= 1'b1;
          c_data  <= job_b;
        end
        SEND_B: begin
          state <= WAIT;
        end
        WAIT: begin
          // The core result is settled by the end of this cycle.
          res   <= c_result;
          rid   <= job_id;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        REJECT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_sched.sv
// tb_calc_sched: self-checking bench for calc_sched.
//
// A small behavioural core sits on the c_* port. Expected results come from
// a plain arithmetic reference function. Winners come from a round-robin
// model that tracks who was served last. The stimulus is a directed sequence
// followed by a randomized run that mixes single requests, simultaneous
// requests and invalid opcodes.
module tb_calc_sched;

  localparam int FIRST_PRIO = 0;

  logic       clk;
  logic       rst;
  logic       req0, req1;
  logic [7:0] a0, a1, b0, b1;
  logic [2:0] op0, op1;
  logic       ack0, ack1, done, rid, err, busy;
  logic [7:0] res;
  logic       c_rst, c_valid;
  logic [7:0] c_data;
  logic [7:0] c_result;

  int checks = 0;
  int errors = 0;

  // Reference-model state
  logic [7:0] pa [2];
  logic [7:0] pb [2];
  logic [2:0] pop [2];
  bit         pend [2];
  bit         last_srv;
  logic [7:0] model_res;

  // Behavioural core state
  logic [1:0] core_cnt;
  logic [7:0] core_a;
  logic [2:0] core_op;

  calc_sched #(.FIRST_PRIO(FIRST_PRIO)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .a0(a0), .a1(a1), .op0(op0), .op1(op1), .b0(b0), .b1(b1),
    .ack0(ack0), .ack1(ack1), .done(done), .rid(rid), .res(res),
    .err(err), .busy(busy), .c_rst(c_rst),
    .c_valid(c_valid), .c_data(c_data), .c_result(c_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] calc(input logic [7:0] a, input logic [2:0] op,
                                      input logic [7:0] b);
    logic [7:0] r;
    case (op)
      3'd0: r = a * b;
      3'd1: r = a + b;
      3'd2: r = a - b;
      3'd3: r = a * a;
      3'd4: r = a + 8'd2;
      3'd5: r = a - 8'd2;
      default: r = 8'd0;
    endcase
    return r;
  endfunction

  function automatic bit is_unary(input logic [2:0] op);
    return (op >= 3'd3) && (op <= 3'd5);
  endfunction

  // The core takes the first strobe as A and the second as the opcode. For a
  // binary opcode the third strobe is B. The result is registered on the
  // edge of the final strobe.
  always @(posedge clk) begin
    if (c_rst) begin
      core_cnt <= 2'd0;
      core_a   <= 8'd0;
      core_op  <= 3'd0;
      c_result <= 8'd0;
    end else if (c_valid) begin
      case (core_cnt)
        2'd0: begin
          core_a   <= c_data;
          core_cnt <= 2'd1;
        end
        2'd1: begin
          core_op <= c_data[2:0];
          if (is_unary(c_data[2:0])) begin
            c_result <= calc(core_a, c_data[2:0], 8'd0);
            core_cnt <= 2'd0;
          end else begin
            core_cnt <= 2'd2;
          end
        end
        default: begin
          c_result <= calc(core_a, core_op, c_data);
          core_cnt <= 2'd0;
        end
      endcase
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input int who, input logic [7:0] a,
                               input logic [2:0] op, input logic [7:0] b);
    pend[who] = 1'b1;
    pa[who]   = a;
    pop[who]  = op;
    pb[who]   = b;
    if (who == 0) begin
      req0 = 1'b1; a0 = a; op0 = op; b0 = b;
    end else begin
      req1 = 1'b1; a1 = a; op1 = op; b1 = b;
    end
  endtask

  task automatic applyReset();
    rst  = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_cvalid", c_valid, 0);
    checkOutput("rst_cdata", c_data, 0);
    checkOutput("rst_res", res, 0);
    checkOutput("rst_flags", {ack0, ack1, done, err, rid}, 0);
    rst       = 1'b0;
    last_srv  = (FIRST_PRIO == 0);
    model_res = 8'd0;
  endtask

  // Entered at the negedge of an IDLE cycle with the pending requests
  // already driven. Walks the full job timeline and returns at the negedge
  // of the following IDLE cycle.
  task automatic serveNext();
    int         w;
    bit         inval;
    bit         un;
    logic [7:0] expv;
    checkOutput("idle_busy", busy, 0);
    if (pend[0] && pend[1]) w = last_srv ? 0 : 1;
    else                    w = pend[1] ? 1 : 0;
    last_srv = (w == 1);
    inval = (pop[w] >= 3'd6);
    un    = is_unary(pop[w]);
    expv  = calc(pa[w], pop[w], pb[w]);

    @(negedge clk);
    checkOutput("t1_ack0", ack0, (w == 0));
    checkOutput("t1_ack1", ack1, (w == 1));
    checkOutput("t1_err", err, inval);
    checkOutput("t1_done", done, 0);
    // Drop the served request and scramble its operands, which must now be ignored.
    pend[w] = 1'b0;
    if (w == 0) begin
      req0 = 1'b0; a0 = 8'($urandom); op0 = 3'($urandom); b0 = 8'($urandom);
    end else begin
      req1 = 1'b0; a1 = 8'($urandom); op1 = 3'($urandom); b1 = 8'($urandom);
    end

    if (inval) begin
      checkOutput("rej_cvalid", c_valid, 0);
      @(negedge clk);
      checkOutput("rej_busy", busy, 0);
      checkOutput("rej_flags", {ack0, ack1, done, err, c_valid}, 0);
      checkOutput("rej_res", res, model_res);
    end else begin
      checkOutput("a_cvalid", c_valid, 1);
      checkOutput("a_cdata", c_data, pa[w]);
      @(negedge clk);
      checkOutput("gapa_cvalid", c_valid, 0);
      checkOutput("gapa_acks", {ack0, ack1}, 0);
      @(negedge clk);
      checkOutput("op_cvalid", c_valid, 1);
      checkOutput("op_cdata", c_data, {5'b0, pop[w]});
      @(negedge clk);
      checkOutput("after_op_cvalid", c_valid, 0);
      if (!un) begin
        @(negedge clk);
        checkOutput("b_cvalid", c_valid, 1);
        checkOutput("b_cdata", c_data, pb[w]);
        @(negedge clk);
        checkOutput("wait_cvalid", c_valid, 0);
        checkOutput("wait_done", done, 0);
      end
      @(negedge clk);
      checkOutput("done", done, 1);
      checkOutput("done_err", err, 0);
      checkOutput("rid", rid, w);
      checkOutput("res", res, expv);
      checkOutput("done_cvalid", c_valid, 0);
      model_res = expv;
      @(negedge clk);
      checkOutput("post_done", done, 0);
      checkOutput("post_busy", busy, 0);
      checkOutput("res_held", res, expv);
    end
  endtask

  initial begin
    int  pat;
    bit  saw_done;
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    a0 = 8'd0; a1 = 8'd0; b0 = 8'd0; b1 = 8'd0; op0 = 3'd0; op1 = 3'd0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    last_srv  = (FIRST_PRIO == 0);
    model_res = 8'd0;
    @(negedge clk);
    @(negedge clk);

    // A request raised during reset must not be granted.
    req0 = 1'b1; a0 = 8'd3; op0 = 3'd1; b0 = 8'd4;
    @(negedge clk);
    checkOutput("rst_vs_req_ack", ack0, 0);
    checkOutput("rst_vs_req_busy", busy, 0);
    checkOutput("rst_crst", c_rst, 1);
    applyReset();
    checkOutput("crst_low", c_rst, 0);

    $display("[TB] directed jobs");
    applyStimulus(0, 8'd7, 3'd0, 8'd6);
    serveNext();
    applyStimulus(1, 8'd16, 3'd3, 8'd0);
    serveNext();
    applyStimulus(0, 8'd1, 3'd2, 8'd3);
    serveNext();
    applyStimulus(0, 8'hFF, 3'd4, 8'd99);
    serveNext();

    $display("[TB] simultaneous requests after reset");
    applyReset();
    applyStimulus(0, 8'd5, 3'd1, 8'd9);
    applyStimulus(1, 8'd4, 3'd5, 8'd0);
    serveNext();
    serveNext();

    $display("[TB] invalid opcode");
    applyStimulus(1, 8'd5, 3'd6, 8'd1);
    serveNext();

    $display("[TB] reset during SEND_B");
    applyStimulus(0, 8'd9, 3'd1, 8'd5);
    @(negedge clk);
    checkOutput("rb_ack0", ack0, 1);
    req0 = 1'b0;
    pend[0] = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("rb_sendb_cvalid", c_valid, 1);
    checkOutput("rb_sendb_cdata", c_data, 8'd5);
    applyReset();
    saw_done = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done || err) saw_done = 1'b1;
    end
    checkOutput("rb_no_done", saw_done, 0);
    applyStimulus(0, 8'd20, 3'd0, 8'd3);
    serveNext();

    $display("[TB] randomized jobs");
    for (int i = 0; i < 60; i++) begin
      if (!pend[0] && !pend[1]) begin
        pat = int'($urandom_range(0, 2));
        if (pat != 1)
          applyStimulus(0, 8'($urandom), 3'($urandom_range(0, 7)), 8'($urandom));
        if (pat != 0)
          applyStimulus(1, 8'($urandom), 3'($urandom_range(0, 7)), 8'($urandom));
      end else if ($urandom_range(0, 1) == 1) begin
        if (!pend[0])
          applyStimulus(0, 8'($urandom), 3'($urandom_range(0, 7)), 8'($urandom));
        else
          applyStimulus(1, 8'($urandom), 3'($urandom_range(0, 7)), 8'($urandom));
      end
      serveNext();
    end
    while (pend[0] || pend[1]) serveNext();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_sched.md
CALC_SCHED -- requirements
Module: calc_sched

Interface
REQ-001 Parameter: FIRST_PRIO, default 0, requester given priority on the first arbitration after reset (0 or 1).
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 req0/req1  in  1  request from requester 0/1; held high until ack.
REQ-005 a0/a1  in  8  operand A; op0/op1  in  3  opcode; b0/b1  in  8  operand B (ignored for unary opcodes).
REQ-006 ack0/ack1  out  1  one-cycle pulse: request accepted and operands latched.
REQ-007 done  out  1  one-cycle pulse: res valid; rid  out  1  requester id of the result.
REQ-008 res  out  8  result, held until the next done.
REQ-009 err  out  1  one-cycle pulse with ack: opcode rejected, no core access.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 c_rst  out  1  core reset, equal to rst combinationally.
REQ-012 c_valid  out  1  core entry strobe; core acts on its rising edge; registered.
REQ-013 c_data  out  8  core entry data; registered.
REQ-014 c_result  in  8  core registered output.

Function
REQ-015 Opcodes: 0 A*B, 1 A+B, 2 A-B (binary); 3 A*A, 4 A+2, 5 A-2 (unary); 6-7 invalid; all results mod 256.
REQ-016 States: IDLE, SEND_A, GAP_A, SEND_OP, GAP_OP, SEND_B, WAIT, DONE, REJECT; one cycle each except IDLE.
REQ-017 IDLE: c_valid=0; if any req is high, select the winner, latch its a/op/b and id at the clock edge, then go to SEND_A (valid opcode) or REJECT (invalid opcode).
REQ-018 Arbitration, round-robin: if both requests are high, grant the requester not served last; after reset, "last served" = !FIRST_PRIO; a lone request is always granted.
REQ-019 The pointer updates on every grant, including rejected ones.
REQ-020 SEND_A: c_valid=1, c_data=A, ack of the granted requester=1 → GAP_A.
REQ-021 GAP_A: c_valid=0 → SEND_OP.
REQ-022 SEND_OP: c_valid=1, c_data={5'b0,op} → GAP_OP if binary, WAIT if unary.
REQ-023 GAP_OP: c_valid=0 → SEND_B.
REQ-024 SEND_B: c_valid=1, c_data=B → WAIT.
REQ-025 WAIT: c_valid=0; res<=c_result at the edge ending WAIT → DONE.
REQ-026 DONE: done=1, rid=latched id → IDLE.
REQ-027 REJECT: ack of the granted requester=1, err=1, c_valid=0, res unchanged, no done → IDLE.
REQ-028 Latency, measuring from t = IDLE cycle with the winning req high: ack at t+1; done at t+7 (binary) or t+5 (unary); the next grant is possible at t+8 / t+6.
REQ-029 Back-to-back: c_valid is never high in two consecutive cycles; there are at least 2 low cycles between jobs.
REQ-030 A req dropped before ack is a withdrawal, with no service; req/operand changes after the grant edge are ignored.
REQ-031 ack0 and ack1 are never high together; done and err are never high together.

Reset
REQ-032 rst=1 forces, at the edge: state=IDLE; c_valid, c_data, ack0, ack1, done, err, rid = 0; res=0; busy=0; round-robin pointer to its initial value.
REQ-033 rst outranks all requests in the same cycle.
REQ-034 Reset mid-job abandons the job, with no done or err; c_rst resets the core in the same cycle so the core and the scheduler resynchronise.

Verification
REQ-035 After reset, req0 with a0=7, op0=0, b0=6 → ack0 at t+1; c_valid pulses carry 7, 0, 6 at t+1, t+3, t+5; done at t+7 with res=0x2A, rid=0.
REQ-036 req1 with a1=16, op1=3 → done at t+5 with res=0x00 (256 truncated), rid=1; no third c_valid pulse.
REQ-037 req0 with a0=1, op0=2, b0=3 → res=0xFE; then a0=0xFF, op0=4 → res=0x01.
REQ-038 req0 and req1 high together after reset → requester 0 served first (done at t+7, rid=0), requester 1 granted in the next IDLE cycle (rid=1); ack order is 0 then 1.
REQ-039 req1 with op1=6 → ack1 and err high together at t+1; c_valid stays 0; no done; res unchanged.
REQ-040 rst asserted during SEND_B → next cycle IDLE with all outputs 0 and no done; a new request then completes with the correct result.
